// File: rtl/tpu_phase_sequencer_pkg.sv
// tpu_seq_pkg: shared state encoding, phase strobes and phase-ordering helper for the TPU phase sequencer.
package tpu_seq_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} seq_state_t;

    localparam logic [2:0] PH_NONE    = 3'b000;
    localparam logic [2:0] PH_LOAD    = 3'b001;
    localparam logic [2:0] PH_COMPUTE = 3'b010;
    localparam logic [2:0] PH_DRAIN   = 3'b100;

    // nz is {drain, compute, load} nonzero flags. Given IDLE it returns the first
    // nonzero phase of a tile; given a phase it returns the next nonzero one.
    // IDLE as the result means the tile has no further phase (end of tile).
    function automatic seq_state_t next_phase(input seq_state_t s, input logic [2:0] nz);
        logic [2:0] m;
        m = nz & ((s == LOAD) ? 3'b110 : (s == COMPUTE) ? 3'b100 : (s == DRAIN) ? 3'b000 : 3'b111);
        return m[0] ? LOAD : m[1] ? COMPUTE : m[2] ? DRAIN : IDLE;
    endfunction

endpackage

// File: rtl/tpu_phase_sequencer_if.sv
// tpu_phase_sequencer_if: control/status bundle between the TPU controller and the phase sequencer.
interface tpu_phase_sequencer_if #(
    parameter int COUNT_WIDTH = 8,
    parameter int TILE_WIDTH  = 4
);
    logic                   start;
    logic                   ready;
    logic                   abort;
    logic                   enable;
    logic [COUNT_WIDTH-1:0] cfg_load_len;
    logic [COUNT_WIDTH-1:0] cfg_op_len;
    logic [COUNT_WIDTH-1:0] cfg_drain_len;
    logic [TILE_WIDTH-1:0]  cfg_num_tiles;
    logic [2:0]             phase;
    logic                   phase_last;
    logic                   row_tick;
    logic                   busy;
    logic                   done;
    logic [TILE_WIDTH-1:0]  tile_idx;
    logic [COUNT_WIDTH-1:0] counter_out;

    modport master (
        output start, abort, enable, cfg_load_len, cfg_op_len, cfg_drain_len, cfg_num_tiles,
        input  ready, phase, phase_last, row_tick, busy, done, tile_idx, counter_out
    );

    modport slave (
        input  start, abort, enable, cfg_load_len, cfg_op_len, cfg_drain_len, cfg_num_tiles,
        output ready, phase, phase_last, row_tick, busy, done, tile_idx, counter_out
    );
endinterface

// File: rtl/tpu_phase_sequencer_phase_counter.sv
// phase_counter: modulo-len cycle counter with clear and stall, flags its final count.
module phase_counter #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [COUNT_WIDTH-1:0] len,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   last
);

    assign last = count == len - COUNT_WIDTH'(1);

    // Clear dominates; otherwise advance on enable and wrap after the final count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= last ? '0 : count + COUNT_WIDTH'(1);
    end

endmodule

// File: rtl/tpu_phase_sequencer.sv
// tpu_phase_sequencer: runs a job as tiles of LOAD/COMPUTE/DRAIN phases with strobes, row ticks and a done pulse.
module tpu_phase_sequencer
    import tpu_seq_pkg::*;
#(
    parameter int COUNT_WIDTH = 8,
    parameter int TILE_WIDTH  = 4,
    parameter int DEPTH       = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    tpu_phase_sequencer_if.slave bus
);

    localparam int ROW_W = $clog2(DEPTH + 1);

    seq_state_t             state, state_nxt, first_cfg, first_sh, after;
    logic [COUNT_WIDTH-1:0] load_len, op_len, drain_len, cur_len, count;
    logic [TILE_WIDTH-1:0]  num_tiles, tile_idx, tile_nxt;
    logic [ROW_W-1:0]       row_count;
    logic [2:0]             nz_cfg, nz_sh;
    logic                   last, row_last, in_phase, phase_done, accept;

    assign in_phase   = state inside {LOAD, COMPUTE, DRAIN};
    assign accept     = bus.start && state == IDLE && !bus.abort;
    assign cur_len    = (state == LOAD) ? load_len : (state == COMPUTE) ? op_len : drain_len;
    assign phase_done = in_phase && bus.enable && last;
    assign nz_cfg     = {bus.cfg_drain_len != '0, bus.cfg_op_len != '0, bus.cfg_load_len != '0};
    assign nz_sh      = {drain_len != '0, op_len != '0, load_len != '0};
    assign first_cfg  = next_phase(IDLE, nz_cfg);
    assign first_sh   = next_phase(IDLE, nz_sh);
    assign after      = next_phase(state, nz_sh);

    // Next state and tile index; abort overrides everything, DONE always falls back to IDLE.
    always_comb begin
        state_nxt = state;
        tile_nxt  = tile_idx;
        if (bus.abort) begin
            state_nxt = IDLE;
            tile_nxt  = '0;
        end else if (state == IDLE) begin
            if (bus.start)
                state_nxt = (bus.cfg_num_tiles == '0 || first_cfg == IDLE) ? DONE : first_cfg;
        end else if (state == DONE) begin
            state_nxt = IDLE;
            tile_nxt  = '0;
        end else if (phase_done) begin
            if (after != IDLE)
                state_nxt = after;
            else if (tile_idx == num_tiles - TILE_WIDTH'(1))
                state_nxt = DONE;
            else begin
                state_nxt = first_sh;
                tile_nxt  = tile_idx + TILE_WIDTH'(1);
            end
        end
    end

    // State and tile registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tile_idx <= '0;
        end else begin
            state    <= state_nxt;
            tile_idx <= tile_nxt;
        end
    end

    // Shadow configuration captured on the accepted start so later cfg changes do not disturb the job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_len  <= '0;
            op_len    <= '0;
            drain_len <= '0;
            num_tiles <= '0;
        end else if (accept) begin
            load_len  <= bus.cfg_load_len;
            op_len    <= bus.cfg_op_len;
            drain_len <= bus.cfg_drain_len;
            num_tiles <= bus.cfg_num_tiles;
        end
    end

    // In-phase counter: held at zero outside phases, wraps to zero when a phase completes.
    phase_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_phase_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (bus.abort || !in_phase),
        .enable (bus.enable),
        .len    (cur_len),
        .count  (count),
        .last   (last)
    );

    // Row counter: restarts on every LOAD entry, including LOAD-to-LOAD across tiles.
    phase_counter #(.COUNT_WIDTH(ROW_W)) u_row_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (bus.abort || state != LOAD || phase_done),
        .enable (bus.enable),
        .len    (ROW_W'(DEPTH)),
        .count  (row_count),
        .last   (row_last)
    );

    assign bus.ready       = state == IDLE;
    assign bus.busy        = state != IDLE;
    assign bus.done        = state == DONE;
    assign bus.phase       = (state == LOAD) ? PH_LOAD : (state == COMPUTE) ? PH_COMPUTE :
                             (state == DRAIN) ? PH_DRAIN : PH_NONE;
    assign bus.phase_last  = in_phase && last;
    assign bus.row_tick    = state == LOAD && row_last;
    assign bus.tile_idx    = tile_idx;
    assign bus.counter_out = count;

endmodule

// File: tb/tb_tpu_phase_sequencer.sv
// tb_tpu_phase_sequencer: directed self-checking bench for tpu_phase_sequencer.
module tb_tpu_phase_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    tpu_phase_sequencer_if #(.COUNT_WIDTH(8), .TILE_WIDTH(4)) bus ();

    tpu_phase_sequencer #(.COUNT_WIDTH(8), .TILE_WIDTH(4), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] pack(int p, int l, int c, int t, int d, int r, int b, int rt);
        return {p[2:0], l[0], c[7:0], t[3:0], d[0], r[0], b[0], rt[0]};
    endfunction

    function automatic logic [19:0] obs();
        return {bus.phase, bus.phase_last, bus.counter_out, bus.tile_idx, bus.done, bus.ready, bus.busy, bus.row_tick};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int l, input int o, input int d, input int t);
        bus.cfg_load_len  = 8'(l);
        bus.cfg_op_len    = 8'(o);
        bus.cfg_drain_len = 8'(d);
        bus.cfg_num_tiles = 4'(t);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] got;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.enable = 1'b1;
        bus.cfg_load_len = '0;
        bus.cfg_op_len = '0;
        bus.cfg_drain_len = '0;
        bus.cfg_num_tiles = '0;
        rst_n = 1'b0;
        #12;
        got = obs();
        checks++;
        if (got !== pack(0, 0, 0, 0, 0, 1, 0, 0)) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", got, pack(0, 0, 0, 0, 0, 1, 0, 0));
        end
        rst_n = 1'b1;
        step();
        got = obs();
        checks++;
        if (got !== pack(0, 0, 0, 0, 0, 1, 0, 0)) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=%h", got, pack(0, 0, 0, 0, 0, 1, 0, 0));
        end
    endtask

    task automatic test_basic();
        logic [19:0] got, exp;
        int o;
        launch(3, 5, 2, 2);
        for (int c = 1; c <= 22; c++) begin
            o = (c - 1) % 10;
            if (c > 21) exp = pack(0, 0, 0, 0, 0, 1, 0, 0);
            else if (c == 21) exp = pack(0, 0, 0, 1, 1, 0, 1, 0);
            else if (o < 3) exp = pack(1, o == 2, o, (c - 1) / 10, 0, 0, 1, 0);
            else if (o < 8) exp = pack(2, o == 7, o - 3, (c - 1) / 10, 0, 0, 1, 0);
            else exp = pack(4, o == 9, o - 8, (c - 1) / 10, 0, 0, 1, 0);
            got = obs();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL basic c=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == 2) begin
                bus.cfg_op_len = 8'd1;
                bus.cfg_load_len = 8'd9;
                bus.cfg_num_tiles = 4'd0;
            end
            step();
        end
    endtask

    task automatic test_row_tick();
        logic [19:0] got, exp;
        launch(10, 1, 1, 1);
        for (int c = 1; c <= 14; c++) begin
            if (c <= 10) exp = pack(1, c == 10, c - 1, 0, 0, 0, 1, (c == 4 || c == 8));
            else if (c == 11) exp = pack(2, 1, 0, 0, 0, 0, 1, 0);
            else if (c == 12) exp = pack(4, 1, 0, 0, 0, 0, 1, 0);
            else if (c == 13) exp = pack(0, 0, 0, 0, 1, 0, 1, 0);
            else exp = pack(0, 0, 0, 0, 0, 1, 0, 0);
            got = obs();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL row_tick c=%0d got=%h exp=%h", c, got, exp);
            end
            step();
        end
    endtask

    task automatic test_zero_skip();
        logic [19:0] got, exp;
        launch(0, 4, 0, 3);
        for (int c = 1; c <= 14; c++) begin
            if (c <= 12) exp = pack(2, (c - 1) % 4 == 3, (c - 1) % 4, (c - 1) / 4, 0, 0, 1, 0);
            else if (c == 13) exp = pack(0, 0, 0, 2, 1, 0, 1, 0);
            else exp = pack(0, 0, 0, 0, 0, 1, 0, 0);
            got = obs();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL zero_skip c=%0d got=%h exp=%h", c, got, exp);
            end
            step();
        end
        launch(5, 5, 5, 0);
        got = obs();
        checks++;
        if (got !== pack(0, 0, 0, 0, 1, 0, 1, 0)) begin
            failures++;
            $display("FAIL zero_tiles_done got=%h exp=%h", got, pack(0, 0, 0, 0, 1, 0, 1, 0));
        end
        step();
        got = obs();
        checks++;
        if (got !== pack(0, 0, 0, 0, 0, 1, 0, 0)) begin
            failures++;
            $display("FAIL zero_tiles_idle got=%h exp=%h", got, pack(0, 0, 0, 0, 0, 1, 0, 0));
        end
        launch(0, 0, 0, 2);
        got = obs();
        checks++;
        if (got !== pack(0, 0, 0, 0, 1, 0, 1, 0)) begin
            failures++;
            $display("FAIL zero_lens_done got=%h exp=%h", got, pack(0, 0, 0, 0, 1, 0, 1, 0));
        end
        step();
    endtask

    task automatic test_stall();
        logic [19:0] got, exp;
        launch(1, 4, 1, 1);
        for (int c = 1; c <= 12; c++) begin
            if (c == 1) exp = pack(1, 1, 0, 0, 0, 0, 1, 0);
            else if (c <= 9) exp = pack(2, (c - 2) / 2 == 3, (c - 2) / 2, 0, 0, 0, 1, 0);
            else if (c == 10) exp = pack(4, 1, 0, 0, 0, 0, 1, 0);
            else if (c == 11) exp = pack(0, 0, 0, 0, 1, 0, 1, 0);
            else exp = pack(0, 0, 0, 0, 0, 1, 0, 0);
            got = obs();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL stall c=%0d got=%h exp=%h", c, got, exp);
            end
            bus.enable = (c >= 2 && c <= 9) ? c[0] : 1'b1;
            step();
        end
        bus.enable = 1'b1;
    endtask

    task automatic test_abort();
        logic [19:0] got, exp;
        int o;
        launch(1, 1, 3, 2);
        for (int c = 1; c <= 9; c++) begin
            o = (c - 1) % 5;
            if (o == 0) exp = pack(1, 1, 0, (c - 1) / 5, 0, 0, 1, 0);
            else if (o == 1) exp = pack(2, 1, 0, (c - 1) / 5, 0, 0, 1, 0);
            else exp = pack(4, o == 4, o - 2, (c - 1) / 5, 0, 0, 1, 0);
            got = obs();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL abort_run c=%0d got=%h exp=%h", c, got, exp);
            end
            step();
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            got = obs();
            checks++;
            if (got !== pack(0, 0, 0, 0, 0, 1, 0, 0)) begin
                failures++;
                $display("FAIL abort_idle k=%0d got=%h exp=%h", c, got, pack(0, 0, 0, 0, 0, 1, 0, 0));
            end
            step();
        end
        bus.abort = 1'b1;
        launch(1, 1, 1, 1);
        bus.abort = 1'b0;
        got = obs();
        checks++;
        if (got !== pack(0, 0, 0, 0, 0, 1, 0, 0)) begin
            failures++;
            $display("FAIL abort_beats_start got=%h exp=%h", got, pack(0, 0, 0, 0, 0, 1, 0, 0));
        end
        launch(2, 0, 0, 1);
        for (int c = 1; c <= 4; c++) begin
            if (c <= 2) exp = pack(1, c == 2, c - 1, 0, 0, 0, 1, 0);
            else if (c == 3) exp = pack(0, 0, 0, 0, 1, 0, 1, 0);
            else exp = pack(0, 0, 0, 0, 0, 1, 0, 0);
            got = obs();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL abort_restart c=%0d got=%h exp=%h", c, got, exp);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        logic [19:0] got;
        launch(1, 6, 1, 1);
        step();
        bus.cfg_op_len = 8'd2;
        step();
        step();
        got = obs();
        checks++;
        if (got !== pack(2, 0, 2, 0, 0, 0, 1, 0)) begin
            failures++;
            $display("FAIL cfg_shadow got=%h exp=%h", got, pack(2, 0, 2, 0, 0, 0, 1, 0));
        end
        #3;
        rst_n = 1'b0;
        #1;
        got = obs();
        checks++;
        if (got !== pack(0, 0, 0, 0, 0, 1, 0, 0)) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", got, pack(0, 0, 0, 0, 0, 1, 0, 0));
        end
        #2;
        rst_n = 1'b1;
        step();
        got = obs();
        checks++;
        if (got !== pack(0, 0, 0, 0, 0, 1, 0, 0)) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=%h", got, pack(0, 0, 0, 0, 0, 1, 0, 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_row_tick();
        test_zero_skip();
        test_stall();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
